// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, with a Mealy sum output and registered word status.
// Define SERIAL_ADDSUB_OVF_EN to compute signed overflow; otherwise overflow is tied to 0.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic                     a,
  input  logic                     b,
  input  logic                     mode,
  input  logic                     cin,
  output logic                     sum,
  output logic                     sum_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     word_done,
  output logic                     carry,
  output logic                     overflow
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          c_q, c_d;
  logic          mode_q, mode_d;
  logic          done_q, done_d;
  logic          carry_q, carry_d;

  logic modeEff, cEff, bEff, cNext, rawSum;

  // Bit 0 takes mode and carry-in from the ports; later bits use the latched values.
  always_comb begin
    modeEff = (state_q == IDLE) ? mode : mode_q;
    if (state_q == IDLE) cEff = mode ? 1'b1 : cin;
    else                 cEff = c_q;
    bEff   = b ^ modeEff;
    rawSum = a ^ bEff ^ cEff;
    cNext  = (a & bEff) | (a & cEff) | (bEff & cEff);
  end

  assign sum       = rawSum & ~reset;
  assign sum_valid = in_valid & ~clear & ~reset;
  assign bit_idx   = idx_q;
  assign word_done = done_q;
  assign carry     = carry_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    carry_d = carry_q;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      c_d     = 1'b0;
    end else if (in_valid) begin
      if (idx_q == LAST) begin
        state_d = IDLE;
        idx_d   = '0;
        c_d     = 1'b0;
        done_d  = 1'b1;
        carry_d = cNext;
      end else begin
        state_d = RUN;
        idx_d   = idx_q + IW'(1);
        c_d     = cNext;
        if (state_q == IDLE) mode_d = mode;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      carry_q <= carry_d;
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow is the carry into the MSB differing from the carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (!clear && in_valid && idx_q == LAST) ovf_d = cEff ^ cNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (WIDTH=8); overflow expectations follow SERIAL_ADDSUB_OVF_EN.
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, clear, in_valid, a, b, mode, cin;
  logic       sum, sum_valid, word_done, carry, overflow;
  logic [2:0] bit_idx;

  int vectors = 0;
  int miscompares = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .a(a), .b(b), .mode(mode), .cin(cin),
    .sum(sum), .sum_valid(sum_valid), .bit_idx(bit_idx),
    .word_done(word_done), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] aw, input logic [7:0] bw,
                               input logic m, input logic ci, input logic [7:0] expSum,
                               input logic expC, input logic expO, input int gapAfter);
    for (int i = 0; i < 8; i++) begin
      clear = 1'b0; in_valid = 1'b1;
      a = aw[i]; b = bw[i]; mode = m; cin = ci;
      #4;
      checkOutput({tag, "_idx"}, 64'(bit_idx), 64'(i));
      checkOutput({tag, "_sum"}, 64'(sum), 64'(expSum[i]));
      checkOutput({tag, "_sv"}, 64'(sum_valid), 64'd1);
      tick();
      if (i == gapAfter) begin
        for (int g = 0; g < 3; g++) begin
          in_valid = 1'b0; mode = ~m; cin = ~ci; a = ~a;
          #4;
          checkOutput({tag, "_gapidx"}, 64'(bit_idx), 64'(i + 1));
          checkOutput({tag, "_gapsv"}, 64'(sum_valid), 64'd0);
          tick();
          checkOutput({tag, "_gapdone"}, 64'(word_done), 64'd0);
        end
      end
    end
    checkOutput({tag, "_done"}, 64'(word_done), 64'd1);
    checkOutput({tag, "_carry"}, 64'(carry), 64'(expC));
    checkOutput({tag, "_ovf"}, 64'(overflow), 64'(expO & OVF_EN));
  endtask

  task automatic idleCycle(input string tag);
    in_valid = 1'b0; clear = 1'b0;
    tick();
    checkOutput({tag, "_doneLow"}, 64'(word_done), 64'd0);
    checkOutput({tag, "_idx0"}, 64'(bit_idx), 64'd0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    a = 1'b0; b = 1'b0; mode = 1'b0; cin = 1'b0;
    #3;
    checkOutput("rst_idx", 64'(bit_idx), 64'd0);
    checkOutput("rst_done", 64'(word_done), 64'd0);
    checkOutput("rst_carry", 64'(carry), 64'd0);
    checkOutput("rst_ovf", 64'(overflow), 64'd0);
    checkOutput("rst_sv", 64'(sum_valid), 64'd0);
    #5 reset = 1'b0;
    tick();

    applyStimulus("add5A33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, -1);
    idleCycle("add5A33");

    applyStimulus("sub1001", 8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, -1);
    idleCycle("sub1001");
    applyStimulus("sub0102", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, -1);
    idleCycle("sub0102");

    applyStimulus("addFF00", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    applyStimulus("add7F01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, -1);
    idleCycle("add7F01");

    applyStimulus("gap5A33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 3);
    idleCycle("gap5A33");

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b1; mode = 1'b0; cin = 1'b0;
      tick();
    end
    clear = 1'b1; in_valid = 1'b1;
    #4;
    checkOutput("clr_sv", 64'(sum_valid), 64'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    checkOutput("clr_idx", 64'(bit_idx), 64'd0);
    checkOutput("clr_done", 64'(word_done), 64'd0);
    checkOutput("clr_carryHold", 64'(carry), 64'd0);
    checkOutput("clr_ovfHold", 64'(overflow), 64'(OVF_EN));
    tick();
    checkOutput("clr_done2", 64'(word_done), 64'd0);
    applyStimulus("add0101", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, -1);
    idleCycle("add0101");

    applyStimulus("addFF00b", 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, -1);
    idleCycle("addFF00b");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 1'b1; b = 1'b1; mode = 1'b0; cin = 1'b0;
      tick();
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("mrst_idx", 64'(bit_idx), 64'd0);
    checkOutput("mrst_done", 64'(word_done), 64'd0);
    checkOutput("mrst_carry", 64'(carry), 64'd0);
    checkOutput("mrst_ovf", 64'(overflow), 64'd0);
    checkOutput("mrst_sv", 64'(sum_valid), 64'd0);
    checkOutput("mrst_sum", 64'(sum), 64'd0);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    tick();
    applyStimulus("post5A33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, -1);
    idleCycle("post5A33");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits, legal range 2..64.
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Port clear  in  1  synchronous abort of the word in progress.
REQ-005 Port in_valid  in  1  a/b carry a valid operand bit this cycle.
REQ-006 Port a  in  1  operand A bit, serial, LSB first.
REQ-007 Port b  in  1  operand B bit, serial, LSB first.
REQ-008 Port mode  in  1  0 = A+B+cin, 1 = A-B; sampled on bit 0 only.
REQ-009 Port cin  in  1  carry-in for add mode; sampled on bit 0 only.
REQ-010 Port sum  out  1  Mealy result bit for the current a/b, combinational.
REQ-011 Port sum_valid  out  1  sum is valid; equals in_valid & ~clear & ~reset.
REQ-012 Port bit_idx  out  $clog2(WIDTH)  index of the next bit to accept, registered.
REQ-013 Port word_done  out  1  registered one-cycle pulse after the last bit.
REQ-014 Port carry  out  1  registered final carry of the last completed word.
REQ-015 Port overflow  out  1  registered signed overflow of the last completed word.

Function
REQ-016 FSM states: IDLE (awaiting bit 0) and RUN (bits 1..WIDTH-1); carry register c holds the Mealy carry state.
REQ-017 Bit accepted when in_valid=1 and clear=0; in_valid=0 holds all state, bit_idx and c unchanged, no output pulses.
REQ-018 IDLE bit accept: latch mode; effective carry-in = cin (mode 0) or 1 (mode 1, cin ignored); go to RUN, bit_idx=1.
REQ-019 Per bit: b' = b ^ mode_eff; sum = a ^ b' ^ c_eff; next c = majority(a, b', c_eff); c_eff is the bit-0 carry-in in IDLE, else c.
REQ-020 mode_eff = mode input on bit 0, latched mode on bits 1..WIDTH-1; mode/cin changes mid-word have no effect.
REQ-021 Last bit (bit_idx=WIDTH-1) accept: register carry=next c, overflow=c_eff^next c, pulse word_done next cycle, return to IDLE, bit_idx=0.
REQ-022 Subtract carry convention: carry=1 means no borrow (A>=B unsigned).
REQ-023 Back-to-back words: bit 0 of the next word is accepted the cycle after the last bit, no bubble.
REQ-024 clear=1 (any state, overrides in_valid): go IDLE, bit_idx=0, c=0, no word_done; carry/overflow keep previous values.
REQ-025 carry and overflow change only at word completion; hold otherwise.

Reset
REQ-026 reset=1 immediately forces IDLE, bit_idx=0, c=0, latched mode=0, word_done=0, carry=0, overflow=0, sum_valid=0.
REQ-027 A word interrupted by reset is discarded; first accepted bit after release is bit 0.

Configuration
REQ-028 Macro SERIAL_ADDSUB_OVF_EN defined: overflow computed per REQ-021.
REQ-029 Macro SERIAL_ADDSUB_OVF_EN undefined: overflow tied to 0, no overflow logic; all other behaviour identical.

Verification (WIDTH=8, SERIAL_ADDSUB_OVF_EN defined unless stated)
REQ-030 Add 0x5A+0x33, cin=0, 8 consecutive valid bits -> sum bits LSB first = 0x8D, word_done pulse cycle after bit 7, carry=0, overflow=1.
REQ-031 Sub 0x10-0x01 -> sum=0x0F, carry=1, overflow=0; repeat 0x01-0x02 -> sum=0xFF, carry=0, overflow=0.
REQ-032 Add 0xFF+0x00, cin=1 -> sum=0x00, carry=1, overflow=0; immediately followed by 0x7F+0x01 -> 0x80, carry=0, overflow=1, no bubble.
REQ-033 Repeat REQ-030 with in_valid low 3 cycles after bit 3 and mode/cin toggled during the gap -> identical result; bit_idx holds 4 during gap.
REQ-034 clear after bit 4 of 0xFF+0xFF, then 0x01+0x01 -> no word_done for aborted word, result 0x02, carry=0, no carry leakage.
REQ-035 reset asserted mid-word between clock edges -> all outputs 0 before next edge; macro undefined build of REQ-030 -> overflow=0, sum unchanged.
